// File: rtl/rvfpm_issue_ctrl.sv
// rvfpm_issue_ctrl
//   In-order issue controller in front of the rvfpm FPU model. Offloaded
//   XIF instructions are buffered with their id until the core commits or
//   kills them. Committed entries are then handed to the FPU over the
//   enable/fpu_ready handshake, strictly in issue order.
//
// Ports
//   ck, rst                     clock (rising edge), async active-low reset
//   issue_valid/ready/instr/id  XIF issue request into the queue
//   commit_valid/id/kill        XIF commit/kill strobe for a queued id
//   enable/instruction/id_out   dispatch of the head entry to the FPU
//   fpu_ready                   FPU accepts the dispatch when high with enable
//   count                       occupied queue entries
//   err_commit                  pulse: commit/kill matched no pending entry
//   err_dup_id                  pulse: accepted issue reused a queued id
//
// Dispatch FSM
//   state  | meaning
//   S_IDLE | nothing to hand over: queue empty or head still pending
//   S_SEND | head is committed, enable high until the FPU takes it
//   S_DROP | head was killed, discard it in one cycle without enable
module rvfpm_issue_ctrl #(
  parameter int X_ID_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                     ck,
  input  logic                     rst,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [INSTR_WIDTH-1:0]   issue_instr,
  input  logic [X_ID_WIDTH-1:0]    issue_id,
  input  logic                     commit_valid,
  input  logic [X_ID_WIDTH-1:0]    commit_id,
  input  logic                     commit_kill,
  output logic                     enable,
  output logic [INSTR_WIDTH-1:0]   instruction,
  output logic [X_ID_WIDTH-1:0]    id_out,
  input  logic                     fpu_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_commit,
  output logic                     err_dup_id
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {E_FREE, E_PEND, E_COMMITTED, E_KILLED} entry_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DROP} state_t;

  entry_t                 ent_st    [DEPTH];
  logic [INSTR_WIDTH-1:0] ent_instr [DEPTH];
  logic [X_ID_WIDTH-1:0]  ent_id    [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, nxt_ptr, srch_idx, cm_idx;
  state_t        state, state_nxt, follow_state;
  logic          issue_fire, pop, have_next, cm_hit, dup_hit;

  assign issue_ready = (count < CNT_FULL);
  assign issue_fire  = issue_valid && issue_ready;
  assign nxt_ptr     = rd_ptr + 1'b1;
  assign have_next   = (count > CNT_ONE);
  assign pop         = ((state == S_SEND) && fpu_ready) || (state == S_DROP);

  assign enable      = (state == S_SEND);
  assign instruction = enable ? ent_instr[rd_ptr] : '0;
  assign id_out      = enable ? ent_id[rd_ptr] : '0;

  // Oldest pending entry with the committed id: scan from the head so the
  // first hit is the oldest. Entries written at this same edge are not yet
  // PEND and therefore cannot match.
  always_comb begin
    cm_hit   = 1'b0;
    cm_idx   = '0;
    srch_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      srch_idx = rd_ptr + PW'(i);
      if (!cm_hit && commit_valid && (ent_st[srch_idx] == E_PEND) &&
          (ent_id[srch_idx] == commit_id)) begin
        cm_hit = 1'b1;
        cm_idx = srch_idx;
      end
    end
  end

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ent_st[i] != E_FREE) && (ent_id[i] == issue_id)) dup_hit = 1'b1;
    end
  end

  // Where to go after the head leaves: decided from the registered state of
  // the entry behind it, so a commit landing on that entry this same edge is
  // only seen one cycle later.
  always_comb begin
    follow_state = S_IDLE;
    if (have_next && (ent_st[nxt_ptr] == E_COMMITTED)) follow_state = S_SEND;
    else if (have_next && (ent_st[nxt_ptr] == E_KILLED)) follow_state = S_DROP;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          if (ent_st[rd_ptr] == E_COMMITTED) state_nxt = S_SEND;
          else if (ent_st[rd_ptr] == E_KILLED) state_nxt = S_DROP;
        end
      end
      S_SEND:  if (fpu_ready) state_nxt = follow_state;
      S_DROP:  state_nxt = follow_state;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_commit <= 1'b0;
      err_dup_id <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_st[i]    <= E_FREE;
        ent_instr[i] <= '0;
        ent_id[i]    <= '0;
      end
    end else begin
      err_commit <= commit_valid && !cm_hit;
      err_dup_id <= issue_fire && dup_hit;

      // The popped slot is never PEND and the write slot is FREE, so these
      // three updates never touch the same entry in one cycle.
      if (cm_hit) ent_st[cm_idx] <= commit_kill ? E_KILLED : E_COMMITTED;
      if (pop) begin
        ent_st[rd_ptr] <= E_FREE;
        rd_ptr         <= nxt_ptr;
      end
      if (issue_fire) begin
        ent_st[wr_ptr]    <= E_PEND;
        ent_instr[wr_ptr] <= issue_instr;
        ent_id[wr_ptr]    <= issue_id;
        wr_ptr            <= wr_ptr + 1'b1;
      end

      case ({issue_fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
module tb_rvfpm_issue_ctrl;
  localparam int XW = 4;
  localparam int D  = 4;
  localparam int IW = 32;

  logic          ck = 1'b0;
  logic          rst = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [IW-1:0] issue_instr = '0;
  logic [XW-1:0] issue_id = '0;
  logic          commit_valid = 1'b0;
  logic [XW-1:0] commit_id = '0;
  logic          commit_kill = 1'b0;
  logic          enable;
  logic [IW-1:0] instruction;
  logic [XW-1:0] id_out;
  logic          fpu_ready = 1'b0;
  logic [$clog2(D):0] count;
  logic          err_commit;
  logic          err_dup_id;

  always #5 ck = ~ck;

  rvfpm_issue_ctrl #(.X_ID_WIDTH(XW), .DEPTH(D), .INSTR_WIDTH(IW)) dut (
    .ck(ck), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_id(issue_id),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .enable(enable), .instruction(instruction), .id_out(id_out),
    .fpu_ready(fpu_ready), .count(count),
    .err_commit(err_commit), .err_dup_id(err_dup_id)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: an ordered list of outstanding instructions, each pending,
  // committed or killed, plus what the dispatcher is doing with the head.
  typedef struct {
    logic [XW-1:0] id;
    logic [IW-1:0] instr;
    int            st;      // 0 pending, 1 committed, 2 killed
  } ent_t;
  ent_t mq[$];
  int   m_act = 0;          // 0 waiting, 1 offering head, 2 discarding head
  bit   m_err_c = 0;
  bit   m_err_d = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input int k);
    if (mq.size() > k) begin
      if (mq[k].st == 1) return 1;
      if (mq[k].st == 2) return 2;
    end
    return 0;
  endfunction

  task automatic model_edge();
    bit fire, pop;
    int nxt, ci;
    fire = issue_valid && (mq.size() < D);
    pop  = ((m_act == 1) && fpu_ready) || (m_act == 2);
    if (m_act == 0)  nxt = classify(0);
    else if (pop)    nxt = classify(1);
    else             nxt = m_act;
    ci = -1;
    if (commit_valid) begin
      for (int k = 0; k < mq.size(); k++)
        if (ci < 0 && mq[k].st == 0 && mq[k].id == commit_id) ci = k;
    end
    m_err_c = commit_valid && (ci < 0);
    m_err_d = 0;
    if (fire) begin
      for (int k = 0; k < mq.size(); k++)
        if (mq[k].id == issue_id) m_err_d = 1;
    end
    if (ci >= 0) mq[ci].st = commit_kill ? 2 : 1;
    if (pop) void'(mq.pop_front());
    if (fire) mq.push_back('{id: issue_id, instr: issue_instr, st: 0});
    m_act = nxt;
  endtask

  task automatic check_model();
    logic          en;
    logic [IW-1:0] ei;
    logic [XW-1:0] eid;
    en  = (m_act == 1);
    ei  = en ? mq[0].instr : '0;
    eid = en ? mq[0].id : '0;
    chk("enable", 32'(enable), 32'(en));
    chk("instruction", instruction, ei);
    chk("id_out", 32'(id_out), 32'(eid));
    chk("count", 32'(count), mq.size());
    chk("issue_ready", 32'(issue_ready), 32'(mq.size() < D));
    chk("err_commit", 32'(err_commit), 32'(m_err_c));
    chk("err_dup_id", 32'(err_dup_id), 32'(m_err_d));
  endtask

  task automatic model_reset();
    mq.delete();
    m_act = 0;
    m_err_c = 0;
    m_err_d = 0;
  endtask

  // One clock: model follows the edge, then outputs are compared at the
  // falling edge and the one-shot strobes are cleared for the next step.
  task automatic tick();
    @(posedge ck);
    model_edge();
    @(negedge ck);
    check_model();
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic do_issue(input logic [XW-1:0] id, input logic [IW-1:0] ins);
    issue_valid = 1'b1; issue_id = id; issue_instr = ins;
  endtask

  task automatic do_commit(input logic [XW-1:0] id, input logic kill);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
  endtask

  task automatic drain();
    fpu_ready = 1'b1;
    for (int k = 0; k < 20 && mq.size() != 0; k++) begin
      for (int j = 0; j < mq.size(); j++)
        if (mq[j].st == 0 && !commit_valid) do_commit(mq[j].id, 1'b1);
      tick();
    end
    chk("drain_empty", 32'(count), 0);
  endtask

  initial begin
    model_reset();
    @(negedge ck);
    check_model();
    chk("reset_issue_ready", 32'(issue_ready), 1);
    rst = 1'b1;

    // 1: single instruction, two cycles issue-to-enable, one-cycle enable
    fpu_ready = 1'b1;
    do_issue(4'd3, 32'h0020_8053); tick();
    do_commit(4'd3, 1'b0);          tick();
    chk("t1_en_c1", 32'(enable), 0);
    tick();
    chk("t1_en_c2", 32'(enable), 1);
    chk("t1_instr", instruction, 32'h0020_8053);
    chk("t1_id", 32'(id_out), 3);
    tick();
    chk("t1_en_c3", 32'(enable), 0);

    // 2: fill, overflow attempt, then one commit frees a slot
    for (int k = 0; k < 4; k++) begin
      do_issue(XW'(k), 32'h1000 + k); tick();
    end
    chk("t2_full_ready", 32'(issue_ready), 0);
    chk("t2_full_count", 32'(count), 4);
    do_issue(4'd7, 32'hbad0_0000); tick();
    chk("t2_ignored_count", 32'(count), 4);
    do_commit(4'd0, 1'b0); tick();
    tick();
    chk("t2_send_id0", 32'(id_out), 0);
    tick();
    chk("t2_after_pop_ready", 32'(issue_ready), 1);
    chk("t2_after_pop_count", 32'(count), 3);
    drain();

    // 3: commit out of order, dispatch stays in order and back-to-back
    do_issue(4'd1, 32'h0000_1111); tick();
    do_issue(4'd2, 32'h0000_2222); tick();
    do_commit(4'd2, 1'b0); tick();
    chk("t3_not_before_head", 32'(enable), 0);
    do_commit(4'd1, 1'b0); tick();
    tick();
    chk("t3_first_en", 32'(enable), 1);
    chk("t3_first_id", 32'(id_out), 1);
    tick();
    chk("t3_second_en", 32'(enable), 1);
    chk("t3_second_id", 32'(id_out), 2);
    tick();
    chk("t3_done", 32'(enable), 0);

    // 4: killed head is dropped silently, next committed one follows
    do_issue(4'd5, 32'h0000_5555); tick();
    do_issue(4'd6, 32'h0000_6666); tick();
    do_commit(4'd5, 1'b1); tick();
    do_commit(4'd6, 1'b0); tick();
    chk("t4_drop_no_en", 32'(enable), 0);
    tick();
    chk("t4_en", 32'(enable), 1);
    chk("t4_id", 32'(id_out), 6);
    tick();
    chk("t4_empty", 32'(count), 0);

    // 5: error pulses
    do_commit(4'd9, 1'b0); tick();
    chk("t5_err_commit", 32'(err_commit), 1);
    chk("t5_count", 32'(count), 0);
    tick();
    chk("t5_err_commit_clear", 32'(err_commit), 0);
    do_issue(4'd2, 32'h0000_0a0a); tick();
    do_issue(4'd2, 32'h0000_0b0b); tick();
    chk("t5_err_dup", 32'(err_dup_id), 1);
    tick();
    chk("t5_err_dup_clear", 32'(err_dup_id), 0);
    drain();

    // 6: FPU stall holds the offer; async reset drops it at once
    fpu_ready = 1'b0;
    do_issue(4'd4, 32'hdead_beef); tick();
    do_commit(4'd4, 1'b0);         tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_hold_en", 32'(enable), 1);
      chk("t6_hold_instr", instruction, 32'hdead_beef);
    end
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_en", 32'(enable), 0);
    chk("t6_rst_count", 32'(count), 0);
    model_reset();
    @(negedge ck);
    check_model();
    rst = 1'b1;
    chk("t6_ready_after", 32'(issue_ready), 1);

    // Random traffic against the reference
    for (int n = 0; n < 600; n++) begin
      fpu_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) do_issue(XW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 9) < 4) begin
        if (mq.size() != 0 && $urandom_range(0, 3) != 0)
          do_commit(mq[$urandom_range(0, mq.size() - 1)].id, ($urandom_range(0, 3) == 0));
        else
          do_commit(XW'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      end
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
